fetch_unit: RTL and testbench

- Instruction-fetch and next-PC stage of the multi-cycle MIPS core, wrapped around the PC register.
- Consumes curPC and fetches the instruction word from instruction memory over a req/ack handshake, then latches it into the instruction register.
- After the control unit resolves the branch or jump, it computes nextPC and issues a one-cycle PCWre pulse to the PC register.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit_next_pc_calc.sv | 31 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch / next-PC stage.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HOLD = 3'd2,
    UPD  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack handshake; master is the fetch unit, slave is the memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection; the fetch FSM registers the result.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0]        fetchPC,
  input  logic [INSTR_W-1:0] instr,
  input  logic [1:0]         PCSrc,
  input  logic               branch_taken,
  input  logic [31:0]        immExt,
  input  logic [31:0]        jrTarget,
  output logic [31:0]        target
);

  logic [31:0] pc4;
  logic        unused_opcode;

  assign pc4           = fetchPC + 32'd4;
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    target = pc4;
    case (PCSrc)
      PCSRC_SEQ: target = pc4;
      PCSRC_BR:  target = branch_taken ? pc4 + {immExt[29:0], 2'b00} : pc4;
      PCSRC_JR:  target = jrTarget;
      PCSRC_J:   target = {pc4[31:28], instr[25:0], 2'b00};
      default:   target = pc4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and next-PC stage around the PC register.
// Optional FETCH_ALIGN_CHECK_EN flags misaligned fetch / jr targets via fetch_err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  fetch_unit_if.master       imem,
  input  logic [31:0]        curPC,
  input  logic               fetch_go,
  input  logic               pc_update,
  input  logic [1:0]         PCSrc,
  input  logic               branch_taken,
  input  logic [31:0]        immExt,
  input  logic [31:0]        jrTarget,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [31:0]        nextPC,
  output logic               PCWre,
  output logic               busy,
  output logic               fetch_err
);

  // state | meaning
  // IDLE  | waiting for fetch_go
  // REQ   | imem_req high, waiting for imem_ack or timeout
  // HOLD  | instr latched, waiting for pc_update
  // UPD   | nextPC stable, PCWre pulsed for one cycle
  // ERR   | fetch timed out or was misaligned; fetch_go retries

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       fetch_pc;
  logic [31:0]       addr_q;
  logic [31:0]       target;
  logic              wait_last;
  logic              pc_misalign;
  logic              jr_misalign;
  logic              req_c;

`ifdef FETCH_ALIGN_CHECK_EN
  assign pc_misalign = (curPC[1:0] != 2'b00);
  assign jr_misalign = (PCSrc == PCSRC_JR) && (jrTarget[1:0] != 2'b00);
`else
  assign pc_misalign = 1'b0;
  assign jr_misalign = 1'b0;
`endif

  assign wait_last = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  next_pc_calc u_next_pc_calc (
    .fetchPC      (fetch_pc),
    .instr        (instr),
    .PCSrc        (PCSrc),
    .branch_taken (branch_taken),
    .immExt       (immExt),
    .jrTarget     (jrTarget),
    .target       (target)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR: if (fetch_go) state_nx = pc_misalign ? ERR : REQ;
      REQ: begin
        if (imem.imem_ack)  state_nx = HOLD;
        else if (wait_last) state_nx = ERR;
      end
      HOLD:    if (pc_update) state_nx = UPD;
      UPD:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_c = (state == REQ);
    PCWre = (state == UPD);
    busy  = (state != IDLE);
  end

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = addr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt    <= '0;
      fetch_pc    <= '0;
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      nextPC      <= RESET_PC;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (fetch_go) begin
            if (pc_misalign) begin
              fetch_err <= 1'b1;
            end else begin
              fetch_pc    <= curPC;
              addr_q      <= {curPC[31:2], 2'b00};
              wait_cnt    <= '0;
              instr_valid <= 1'b0;
              // only a retry out of ERR clears the sticky flag
              if (state == ERR) fetch_err <= 1'b0;
            end
          end
        end
        REQ: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
          end else if (wait_last) begin
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (pc_update) begin
            nextPC <= target;
            if (jr_misalign) fetch_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {instr, nextPC}, monitor checks on PCWre.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] curPC;
  logic        fetch_go;
  logic        pc_update;
  logic [1:0]  PCSrc;
  logic        branch_taken;
  logic [31:0] immExt;
  logic [31:0] jrTarget;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] nextPC;
  logic        PCWre;
  logic        busy;
  logic        fetch_err;

  fetch_unit_if imem ();

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4), .WAIT_W(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem         (imem),
    .curPC        (curPC),
    .fetch_go     (fetch_go),
    .pc_update    (pc_update),
    .PCSrc        (PCSrc),
    .branch_taken (branch_taken),
    .immExt       (immExt),
    .jrTarget     (jrTarget),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .nextPC       (nextPC),
    .PCWre        (PCWre),
    .busy         (busy),
    .fetch_err    (fetch_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // monitor: one pop per PCWre pulse, plus pulse-width check
  int pw_run = 0;
  initial begin
    forever begin
      @(negedge CLK);
      if (PCWre === 1'b1) begin
        if (pw_run == 0) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_pcwre", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("upd_nextPC", nextPC, e.npc);
            chk("upd_instr", instr, e.instr);
            chk("upd_instr_valid", {31'd0, instr_valid}, 32'd1);
          end
        end
        pw_run++;
      end else if (pw_run > 0) begin
        chk("pcwre_width", pw_run, 32'd1);
        pw_run = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_fetch(input logic [31:0] pc, input int waits, input logic [31:0] rdata);
    @(negedge CLK);
    curPC    = pc;
    fetch_go = 1'b1;
    @(negedge CLK);
    fetch_go = 1'b0;
    chk("req_high", {31'd0, imem.imem_req}, 32'd1);
    chk("req_addr", imem.imem_addr, {pc[31:2], 2'b00});
    repeat (waits) @(negedge CLK);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = rdata;
    @(negedge CLK);
    imem.imem_ack = 1'b0;
    chk("hold_instr", instr, rdata);
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_req_low", {31'd0, imem.imem_req}, 32'd0);
  endtask

  task automatic do_update(input logic [1:0] src, input logic taken, input logic [31:0] imm,
                           input logic [31:0] jr, input logic [31:0] exp_instr,
                           input logic [31:0] exp_npc);
    exp_t e;
    PCSrc        = src;
    branch_taken = taken;
    immExt       = imm;
    jrTarget     = jr;
    pc_update    = 1'b1;
    e.instr      = exp_instr;
    e.npc        = exp_npc;
    sb.push_back(e);
    @(negedge CLK);
    pc_update = 1'b0;
    @(negedge CLK);
    chk("idle_after_upd", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RST             = 1'b1;
    curPC           = '0;
    fetch_go        = 1'b0;
    pc_update       = 1'b0;
    PCSrc           = 2'b00;
    branch_taken    = 1'b0;
    immExt          = '0;
    jrTarget        = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    #1 RST = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_nextPC", nextPC, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // sequential fetch, ack after 2 wait cycles
    do_fetch(32'h0000_0100, 2, 32'h2001_0005);
    do_update(2'b00, 1'b0, 32'h0, 32'h0, 32'h2001_0005, 32'h0000_0104);
    chk("valid_after_upd", {31'd0, instr_valid}, 32'd1);

    // branch taken / not taken with immExt = -1
    do_fetch(32'h0000_0200, 0, 32'h1000_FFFF);
    do_update(2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1000_FFFF, 32'h0000_0200);
    do_fetch(32'h0000_0200, 1, 32'h1000_FFFF);
    do_update(2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h1000_FFFF, 32'h0000_0204);

    // jump and jr
    do_fetch(32'hF000_0010, 0, 32'h0800_0040);
    do_update(2'b11, 1'b0, 32'h0, 32'h0, 32'h0800_0040, 32'hF000_0100);
    do_fetch(32'h0000_0300, 0, 32'h03E0_0008);
    do_update(2'b10, 1'b0, 32'h0, 32'h0000_003C, 32'h03E0_0008, 32'h0000_003C);

    // timeout after 4 REQ cycles (MAX_WAIT = 4)
    @(negedge CLK);
    curPC    = 32'h0000_0400;
    fetch_go = 1'b1;
    @(negedge CLK);
    fetch_go = 1'b0;
    repeat (3) @(negedge CLK);
    chk("to_req_still_high", {31'd0, imem.imem_req}, 32'd1);
    chk("to_no_err_yet", {31'd0, fetch_err}, 32'd0);
    @(negedge CLK);
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req_low", {31'd0, imem.imem_req}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge CLK);
    chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);

    // retry clears the error; ack in the 4th REQ cycle wins over the timeout
    do_fetch(32'h0000_0400, 3, 32'hAABB_CCDD);
    chk("retry_err_clear", {31'd0, fetch_err}, 32'd0);
    do_update(2'b00, 1'b0, 32'h0, 32'h0, 32'hAABB_CCDD, 32'h0000_0404);

    // misaligned fetch address
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge CLK);
    curPC    = 32'h0000_0102;
    fetch_go = 1'b1;
    @(negedge CLK);
    fetch_go = 1'b0;
    chk("mis_no_req", {31'd0, imem.imem_req}, 32'd0);
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    do_fetch(32'h0000_0500, 0, 32'h0000_0008);
    do_update(2'b10, 1'b0, 32'h0, 32'h0000_0080, 32'h0000_0008, 32'h0000_0080);
`else
    do_fetch(32'h0000_0102, 0, 32'h0000_0008);
    chk("mis_no_err", {31'd0, fetch_err}, 32'd0);
    do_update(2'b10, 1'b0, 32'h0, 32'h0000_0080, 32'h0000_0008, 32'h0000_0080);
`endif

    // asynchronous reset in the middle of REQ
    @(negedge CLK);
    curPC    = 32'h0000_0040;
    fetch_go = 1'b1;
    @(negedge CLK);
    fetch_go = 1'b0;
    chk("pre_rst_req", {31'd0, imem.imem_req}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("arst_addr", imem.imem_addr, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_nextPC", nextPC, 32'h0);
    chk("arst_pcwre", {31'd0, PCWre}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, fetch_err}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
